mips_test_monitor: RTL



---
 rtl/mips_test_monitor.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mips_test_monitor.sv
// Test monitor for a MIPS core: holds the core in reset, runs it until its test value matches
// the expected value or a cycle limit expires, and traces value changes. Optional macro: MIPS_MON_SIGNATURE_EN.
module mips_test_monitor #(
  parameter int unsigned VALUE_W      = 16,
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned MAX_CYCLES   = 70,
  parameter int unsigned TRACE_DEPTH  = 8
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  start,
  input  logic [VALUE_W-1:0]                    expect_value,
  input  logic [VALUE_W-1:0]                    test_value,
  output logic                                  core_reset_n,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  pass,
  output logic                                  timeout,
  output logic [$clog2(MAX_CYCLES+1)-1:0]       cycle_cnt,
  output logic [$clog2(TRACE_DEPTH):0]          trace_cnt,
  output logic                                  trace_ovf,
  input  logic [$clog2(TRACE_DEPTH)-1:0]        rd_addr,
  output logic [VALUE_W-1:0]                    rd_data,
  output logic [31:0]                           signature
);

  localparam int unsigned AW  = $clog2(TRACE_DEPTH);
  localparam int unsigned TW  = AW + 1;
  localparam int unsigned CW  = $clog2(MAX_CYCLES + 1);
  localparam int unsigned CW1 = CW + 1;
  localparam int unsigned HW  = $clog2(RESET_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_RUN, S_DONE} state_t;

  state_t               r_state;
  state_t               w_next;
  logic [HW-1:0]        r_hold_cnt;
  logic [VALUE_W-1:0]   r_expect;
  logic [VALUE_W-1:0]   r_last;
  logic [CW-1:0]        r_cycle_cnt;
  logic [TW-1:0]        r_trace_cnt;
  logic                 r_trace_ovf;
  logic                 r_core_rst_n;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_pass;
  logic                 r_timeout;
  logic [VALUE_W-1:0]   r_rd_data;
  logic [VALUE_W-1:0]   r_mem [TRACE_DEPTH];

  logic                 w_start_acc;
  logic                 w_run;
  logic                 w_hold_last;
  logic                 w_match;
  logic [CW:0]          w_cnt_inc;
  logic                 w_limit;
  logic                 w_first;
  logic                 w_diff;
  logic                 w_full;
  logic                 w_wr;
  logic                 w_lost;

  assign w_start_acc = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_run       = (r_state == S_RUN);
  assign w_hold_last = (r_hold_cnt == HW'(RESET_CYCLES - 1));
  assign w_match     = (test_value == r_expect);
  assign w_cnt_inc   = {1'b0, r_cycle_cnt} + CW1'(1);
  assign w_limit     = (w_cnt_inc >= CW1'(MAX_CYCLES));
  assign w_first     = (r_cycle_cnt == '0);
  assign w_diff      = (test_value != r_last);
  assign w_full      = (r_trace_cnt == TW'(TRACE_DEPTH));
  assign w_wr        = w_run && (w_first || (w_diff && !w_full));
  assign w_lost      = w_run && !w_first && w_diff && w_full;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: if (start) w_next = S_HOLD;
      S_HOLD:         if (w_hold_last) w_next = S_RUN;
      S_RUN:          if (w_match || w_limit) w_next = S_DONE;
      default:        w_next = S_IDLE;
    endcase
  end

  // Run bookkeeping; busy and core reset follow the state being entered so they stay registered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hold_cnt   <= '0;
      r_expect     <= '0;
      r_last       <= '0;
      r_cycle_cnt  <= '0;
      r_trace_cnt  <= '0;
      r_trace_ovf  <= 1'b0;
      r_core_rst_n <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_core_rst_n <= (w_next == S_RUN);
      r_busy       <= (w_next == S_HOLD) || (w_next == S_RUN);
      if (w_start_acc) begin
        r_hold_cnt  <= '0;
        r_expect    <= expect_value;
        r_cycle_cnt <= '0;
        r_trace_cnt <= '0;
        r_trace_ovf <= 1'b0;
        r_done      <= 1'b0;
        r_pass      <= 1'b0;
        r_timeout   <= 1'b0;
      end else if (r_state == S_HOLD) begin
        r_hold_cnt <= r_hold_cnt + HW'(1);
      end else if (w_run) begin
        r_cycle_cnt <= w_limit ? CW'(MAX_CYCLES) : w_cnt_inc[CW-1:0];
        if (w_wr) begin
          r_trace_cnt <= r_trace_cnt + TW'(1);
          r_last      <= test_value;
        end
        if (w_lost) r_trace_ovf <= 1'b1;
        if (w_match) begin
          r_done <= 1'b1;
          r_pass <= 1'b1;
        end else if (w_limit) begin
          r_done    <= 1'b1;
          r_timeout <= 1'b1;
        end
      end
    end
  end

  // Trace storage is not reset; unwritten entries read back stale
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_trace_cnt[AW-1:0]] <= test_value;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rd_data <= '0;
    else          r_rd_data <= r_mem[rd_addr];
  end

`ifdef MIPS_MON_SIGNATURE_EN
  logic [31:0] r_sig;
  logic [31:0] w_tv32;

  if (VALUE_W >= 32) begin : g_tv_trunc
    assign w_tv32 = test_value[31:0];
  end else begin : g_tv_ext
    assign w_tv32 = {{(32 - VALUE_W){1'b0}}, test_value};
  end

  // Rotate-left-and-xor signature over every RUN cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         r_sig <= '0;
    else if (w_start_acc) r_sig <= '0;
    else if (w_run)       r_sig <= {r_sig[30:0], r_sig[31]} ^ w_tv32;
  end

  assign signature = r_sig;
`else
  assign signature = 32'd0;
`endif

  assign core_reset_n = r_core_rst_n;
  assign busy         = r_busy;
  assign done         = r_done;
  assign pass         = r_pass;
  assign timeout      = r_timeout;
  assign cycle_cnt    = r_cycle_cnt;
  assign trace_cnt    = r_trace_cnt;
  assign trace_ovf    = r_trace_ovf;
  assign rd_data      = r_rd_data;

endmodule
